// File: rtl/if_stage_if.sv
// Instruction-memory fetch channel between if_stage and instruction memory.
//   req   : fetch request (master -> slave)
//   addr  : word address, held stable while req=1 and ready=0 (master -> slave)
//   rdata : fetched word, valid when ready=1 (slave -> master)
//   ready : request completes this cycle (slave -> master)
interface if_stage_if #(
  parameter int unsigned PC_WIDTH    = 32,
  parameter int unsigned INSTR_WIDTH = 32
);
  logic                   req;
  logic [PC_WIDTH-1:0]    addr;
  logic [INSTR_WIDTH-1:0] rdata;
  logic                   ready;

  modport master (output req, output addr, input rdata, input ready);
  modport slave  (input req, input addr, output rdata, output ready);
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage. Owns the PC, issues one word-addressed fetch at a time over
// the imem channel and presents a registered instruction/PC pair to decode.
// Ports:
//   clk, rst                  : clock, asynchronous active-low reset
//   stall_pipeline            : hold outputs and PC
//   is_jump, jump_addr        : redirect from decode (ignored while stalled)
//   branch_taken, branch_addr : redirect from MEM (wins over stall and over jump)
//   imem                      : fetch channel (master side)
//   out_instruction/pc/valid  : registered instruction to decode; bubble is all-zero
module if_stage #(
  parameter int unsigned       PC_WIDTH    = 32,
  parameter int unsigned       INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall_pipeline,
  input  logic                   is_jump,
  input  logic [PC_WIDTH-1:0]    jump_addr,
  input  logic                   branch_taken,
  input  logic [PC_WIDTH-1:0]    branch_addr,
  if_stage_if.master             imem,
  output logic [INSTR_WIDTH-1:0] out_instruction,
  output logic [PC_WIDTH-1:0]    out_pc,
  output logic                   out_valid
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StFetch = 2'd1;
  localparam logic [1:0] StHold  = 2'd2;
  localparam logic [1:0] StDrain = 2'd3;

  localparam logic [PC_WIDTH-1:0] PcOne = {{(PC_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]             state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [PC_WIDTH-1:0]    drain_addr_q, drain_addr_d;
  logic [INSTR_WIDTH-1:0] out_instr_q, out_instr_d;
  logic [PC_WIDTH-1:0]    out_pc_q, out_pc_d;
  logic                   out_valid_q, out_valid_d;
  logic [INSTR_WIDTH-1:0] buf_instr_q, buf_instr_d;
  logic [PC_WIDTH-1:0]    buf_pc_q, buf_pc_d;

  logic                   redirect;
  logic [PC_WIDTH-1:0]    target;

  assign redirect = branch_taken | (is_jump & ~stall_pipeline);
  assign target   = branch_taken ? branch_addr : jump_addr;

  // Request is combinational on state so an asynchronous reset drops it immediately.
  // DRAIN keeps presenting the abandoned address since pc already holds the new target.
  assign imem.req  = (state_q == StFetch) || (state_q == StDrain);
  assign imem.addr = (state_q == StDrain) ? drain_addr_q : pc_q;

  assign out_instruction = out_instr_q;
  assign out_pc          = out_pc_q;
  assign out_valid       = out_valid_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    out_instr_d  = out_instr_q;
    out_pc_d     = out_pc_q;
    out_valid_d  = out_valid_q;
    buf_instr_d  = buf_instr_q;
    buf_pc_d     = buf_pc_q;

    // Any redirect flushes the output register and the buffer to a bubble.
    if (redirect) begin
      pc_d        = target;
      out_instr_d = '0;
      out_pc_d    = '0;
      out_valid_d = 1'b0;
      buf_instr_d = '0;
      buf_pc_d    = '0;
    end

    case (state_q)
      StIdle: begin
        state_d = StFetch;
      end
      StFetch: begin
        if (redirect) begin
          if (!imem.ready) begin
            drain_addr_d = pc_q;
            state_d      = StDrain;
          end
        end else if (imem.ready) begin
          pc_d = pc_q + PcOne;
          if (stall_pipeline) begin
            buf_instr_d = imem.rdata;
            buf_pc_d    = pc_q;
            state_d     = StHold;
          end else begin
            out_instr_d = imem.rdata;
            out_pc_d    = pc_q;
            out_valid_d = 1'b1;
          end
        end else if (!stall_pipeline) begin
          // Decode consumed the last word and nothing new arrived: present a bubble.
          out_instr_d = '0;
          out_pc_d    = '0;
          out_valid_d = 1'b0;
        end
      end
      StHold: begin
        if (redirect) begin
          state_d = StFetch;
        end else if (!stall_pipeline) begin
          out_instr_d = buf_instr_q;
          out_pc_d    = buf_pc_q;
          out_valid_d = 1'b1;
          state_d     = StFetch;
        end
      end
      StDrain: begin
        // Returned word belongs to the abandoned address and is discarded.
        if (imem.ready) begin
          state_d = StFetch;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      pc_q         <= RESET_PC;
      drain_addr_q <= '0;
      out_instr_q  <= '0;
      out_pc_q     <= '0;
      out_valid_q  <= 1'b0;
      buf_instr_q  <= '0;
      buf_pc_q     <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      out_instr_q  <= out_instr_d;
      out_pc_q     <= out_pc_d;
      out_valid_q  <= out_valid_d;
      buf_instr_q  <= buf_instr_d;
      buf_pc_q     <= buf_pc_d;
    end
  end

endmodule
